// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_PORTS = 2;
    localparam int unsigned TagW      = 32;
    localparam int unsigned WordW     = 32;

    typedef logic [WordW-1:0] memory_word_t;
    typedef logic [TagW-1:0]  tag_t;

    // Tag 0 marks an idle bus slot.
    typedef struct packed {
        tag_t         tag;
        memory_word_t value;
    } cdb_t;

    function automatic logic [31:0] wrap_inc(logic [31:0] idx, logic [31:0] n);
        return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational round-robin picker: first and second eligible requester starting at rr_ptr_i.
module cdb_arbiter_rr_pick2 #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [PtrW-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant1_o,
    output logic [NUM_REQ-1:0] grant2_o,
    output logic [PtrW-1:0]    idx1_o,
    output logic [PtrW-1:0]    idx2_o,
    output logic               valid1_o,
    output logic               valid2_o
);

    logic [PtrW-1:0] idx;

    always_comb begin
        grant1_o = '0;
        grant2_o = '0;
        idx1_o   = '0;
        idx2_o   = '0;
        valid1_o = 1'b0;
        valid2_o = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PtrW'((32'(rr_ptr_i) + k) % NUM_REQ);
            if (elig_i[idx]) begin
                if (!valid1_o) begin
                    valid1_o      = 1'b1;
                    grant1_o[idx] = 1'b1;
                    idx1_o        = idx;
                end else if (!valid2_o) begin
                    valid2_o      = 1'b1;
                    grant2_o[idx] = 1'b1;
                    idx2_o        = idx;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers one result per producer and broadcasts up to two per cycle on registered cdb1/cdb2.
// Define CDB_ARB_BYPASS_EN to let an empty-holding requester compete in the cycle it presents.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*TagW-1:0]      req_tag_i,
    input  logic [NUM_REQ*WordW-1:0]     req_value_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [TagW-1:0]              cdb1_tag_o,
    output logic [WordW-1:0]             cdb1_value_o,
    output logic [TagW-1:0]              cdb2_tag_o,
    output logic [WordW-1:0]             cdb2_value_o,
    output logic [$clog2(NUM_REQ+1)-1:0] pending_o
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0]         hold_v_q, hold_v_d;
    tag_t [NUM_REQ-1:0]         hold_tag_q, hold_tag_d;
    memory_word_t [NUM_REQ-1:0] hold_value_q, hold_value_d;
    logic [PtrW-1:0]            rr_ptr_q, rr_ptr_d;
    cdb_t [CDB_PORTS-1:0]       cdb_q, cdb_d;

    tag_t [NUM_REQ-1:0]         in_tag;
    memory_word_t [NUM_REQ-1:0] in_value;
    logic [NUM_REQ-1:0]         elig, grant, grant1, grant2, bypass, load;
    logic [PtrW-1:0]            idx1, idx2;
    logic                       valid1, valid2;
    logic                       accept_en;

    assign in_tag    = req_tag_i;
    assign in_value  = req_value_i;
    assign accept_en = !reset_i && !flush_i;

`ifdef CDB_ARB_BYPASS_EN
    assign elig = hold_v_q | (req_valid_i & {NUM_REQ{accept_en}});
`else
    assign elig = hold_v_q;
`endif

    cdb_arbiter_rr_pick2 #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .elig_i   (elig),
        .rr_ptr_i (rr_ptr_q),
        .grant1_o (grant1),
        .grant2_o (grant2),
        .idx1_o   (idx1),
        .idx2_o   (idx2),
        .valid1_o (valid1),
        .valid2_o (valid2)
    );

    assign grant       = grant1 | grant2;
    // A grant to an empty holding reg can only be a same-cycle bypass.
    assign bypass      = grant & ~hold_v_q;
    assign req_ready_o = {NUM_REQ{accept_en}} & (~hold_v_q | grant);
    assign load        = req_valid_i & req_ready_o & ~bypass;

    always_comb begin
        cdb_d = '0;
        if (valid1) begin
            cdb_d[0].tag   = hold_v_q[idx1] ? hold_tag_q[idx1]   : in_tag[idx1];
            cdb_d[0].value = hold_v_q[idx1] ? hold_value_q[idx1] : in_value[idx1];
        end
        if (valid2) begin
            cdb_d[1].tag   = hold_v_q[idx2] ? hold_tag_q[idx2]   : in_tag[idx2];
            cdb_d[1].value = hold_v_q[idx2] ? hold_value_q[idx2] : in_value[idx2];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (valid2) begin
            rr_ptr_d = PtrW'(wrap_inc(32'(idx2), NUM_REQ));
        end else if (valid1) begin
            rr_ptr_d = PtrW'(wrap_inc(32'(idx1), NUM_REQ));
        end
    end

    always_comb begin
        hold_v_d     = hold_v_q;
        hold_tag_d   = hold_tag_q;
        hold_value_d = hold_value_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                hold_v_d[i] = 1'b0;
            end
            // A load in the same cycle as a grant keeps the slot busy with the new result.
            if (load[i]) begin
                hold_v_d[i]     = 1'b1;
                hold_tag_d[i]   = in_tag[i];
                hold_value_d[i] = in_value[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            hold_v_q <= '0;
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
        hold_tag_q   <= hold_tag_d;
        hold_value_q <= hold_value_d;
    end

    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pending_o = pending_o + CntW'(hold_v_q[i]);
        end
    end

    assign cdb1_tag_o   = cdb_q[0].tag;
    assign cdb1_value_o = cdb_q[0].value;
    assign cdb2_tag_o   = cdb_q[1].tag;
    assign cdb2_value_o = cdb_q[1].value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int N = 4;
`ifdef CDB_ARB_BYPASS_EN
    localparam bit Byp   = 1'b1;
    localparam int Lat   = 1;
    localparam int Pend6 = 1;
`else
    localparam bit Byp   = 1'b0;
    localparam int Lat   = 2;
    localparam int Pend6 = 3;
`endif

    logic            clk = 1'b0;
    logic            reset, flush;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_tag;
    logic [N*32-1:0] req_value;
    logic [N-1:0]    req_ready;
    logic [31:0]     cdb1_tag, cdb1_value, cdb2_tag, cdb2_value;
    logic [2:0]      pending;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          mv[N];
    logic [31:0] mt[N];
    logic [31:0] mx[N];
    int          mptr = 0;
    logic [31:0] m1t = 0, m1v = 0, m2t = 0, m2v = 0;

    int obs[$];

    cdb_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_tag_i    (req_tag),
        .req_value_i  (req_value),
        .req_ready_o  (req_ready),
        .cdb1_tag_o   (cdb1_tag),
        .cdb1_value_o (cdb1_value),
        .cdb2_tag_o   (cdb2_tag),
        .cdb2_value_o (cdb2_value),
        .pending_o    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] in_tag(int i);
        return req_tag[i*32 +: 32];
    endfunction

    function automatic logic [31:0] in_val(int i);
        return req_value[i*32 +: 32];
    endfunction

    // Eligible requesters in rotation order from mptr; first two win.
    function automatic void pick(output int s1, output int s2);
        int q[$];
        for (int k = 0; k < N; k++) begin
            int i = (mptr + k) % N;
            if (mv[i] || (Byp && req_valid[i] && !reset && !flush)) q.push_back(i);
        end
        s1 = (q.size() > 0) ? q[0] : -1;
        s2 = (q.size() > 1) ? q[1] : -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int s1, s2;
        logic [N-1:0] r;
        pick(s1, s2);
        for (int i = 0; i < N; i++)
            r[i] = !reset && !flush && (!mv[i] || i == s1 || i == s2);
        return r;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mv[i]);
        return c;
    endfunction

    task automatic model_step();
        int s1, s2;
        logic [N-1:0] rdy;
        if (reset || flush) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mptr = 0;
            m1t = 0; m1v = 0; m2t = 0; m2v = 0;
        end else begin
            pick(s1, s2);
            rdy = exp_ready();
            m1t = 0; m1v = 0; m2t = 0; m2v = 0;
            if (s1 >= 0) begin
                m1t = mv[s1] ? mt[s1] : in_tag(s1);
                m1v = mv[s1] ? mx[s1] : in_val(s1);
            end
            if (s2 >= 0) begin
                m2t = mv[s2] ? mt[s2] : in_tag(s2);
                m2v = mv[s2] ? mx[s2] : in_val(s2);
            end
            for (int i = 0; i < N; i++) begin
                bit g = (i == s1) || (i == s2);
                bit byp = g && !mv[i];
                if (g) mv[i] = 1'b0;
                if (req_valid[i] && rdy[i] && !byp) begin
                    mv[i] = 1'b1;
                    mt[i] = in_tag(i);
                    mx[i] = in_val(i);
                end
            end
            if (s2 >= 0) mptr = (s2 + 1) % N;
            else if (s1 >= 0) mptr = (s1 + 1) % N;
        end
    endtask

    task automatic compare_all();
        chk("req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("cdb1_tag", cdb1_tag, m1t);
        chk("cdb1_value", cdb1_value, m1v);
        chk("cdb2_tag", cdb2_tag, m2t);
        chk("cdb2_value", cdb2_value, m2v);
        chk("pending", 32'(pending), 32'(mcount()));
        chk("cdb2_without_cdb1", 32'(cdb2_tag != 0 && cdb1_tag == 0), 0);
        for (int i = 0; i < N; i++)
            if (req_valid[i] && !reset) chk("tag_nonzero", 32'(in_tag(i) == 0), 0);
    endtask

    // Inputs change at negedge; compare before the edge, then advance the model on it.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_req(int i, logic [31:0] t, logic [31:0] v);
        req_tag[i*32 +: 32]   = t;
        req_value[i*32 +: 32] = v;
    endtask

    // Present mask for one cycle and wait until those results can reach the bus.
    task automatic present(logic [N-1:0] mask);
        req_valid = mask;
        tick();
        req_valid = '0;
        repeat (Lat - 1) tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_value = '0;
        for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mt[i] = 0; mx[i] = 0; end
        repeat (2) @(negedge clk);

        // Reset holds everything idle even with requests presented
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(100 + i));
        req_valid = 4'b1111;
        tick(); tick();
        chk("t1_ready", 32'(req_ready), 0);
        chk("t1_cdb1_tag", cdb1_tag, 0);
        chk("t1_cdb2_tag", cdb2_tag, 0);
        chk("t1_pending", 32'(pending), 0);
        req_valid = '0; reset = 1'b0;
        tick();

        // Single result
        set_req(0, 5, 32'hDEAD);
        present(4'b0001);
        chk("t2_cdb1_tag", cdb1_tag, 5);
        chk("t2_cdb1_value", cdb1_value, 32'hDEAD);
        chk("t2_cdb2_tag", cdb2_tag, 0);
        chk("t2_model_ptr", 32'(mptr), 1);
        tick();
        chk("t2_idle", cdb1_tag, 0);

        // Dual grant and round robin from pointer 0
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(100 + i));
        present(4'b1111);
        chk("t3a_cdb1_tag", cdb1_tag, 1);
        chk("t3a_cdb2_tag", cdb2_tag, 2);
        tick();
        chk("t3b_cdb1_tag", cdb1_tag, 3);
        chk("t3b_cdb2_tag", cdb2_tag, 4);
        chk("t3b_cdb2_value", cdb2_value, 103);
        chk("t3_model_ptr", 32'(mptr), 0);
        tick();

        // Wrap from requester 3 back to requester 0
        set_req(2, 9, 32'h99);
        present(4'b0100);
        chk("t4_pre_tag", cdb1_tag, 9);
        chk("t4_pre_ptr", 32'(mptr), 3);
        set_req(0, 10, 32'hA0);
        set_req(3, 11, 32'hB3);
        present(4'b1001);
        chk("t4_cdb1_tag", cdb1_tag, 11);
        chk("t4_cdb1_value", cdb1_value, 32'hB3);
        chk("t4_cdb2_tag", cdb2_tag, 10);
        chk("t4_model_ptr", 32'(mptr), 1);

        // Back-to-back streaming on one requester
        req_valid = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            set_req(1, 32'(7 + j), 32'(70 + j));
            #1;
            chk("t5_ready", 32'(req_ready[1]), 1);
            tick();
            obs.push_back(int'(cdb1_tag));
        end
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            obs.push_back(int'(cdb1_tag));
        end
        for (int j = 0; j < 3; j++) chk("t5_seq", 32'(obs[Lat - 1 + j]), 32'(7 + j));

        // Flush drops buffered and same-cycle results
        for (int i = 0; i < 3; i++) set_req(i, 32'(20 + i), 32'(200 + i));
        req_valid = 4'b0111;
        tick();
        chk("t6_pending", 32'(pending), 32'(Pend6));
        set_req(3, 23, 32'h230);
        req_valid = 4'b1000;
        flush = 1'b1;
        #1;
        chk("t6_ready", 32'(req_ready), 0);
        tick();
        flush = 1'b0; req_valid = '0;
        chk("t6_cdb1_tag", cdb1_tag, 0);
        chk("t6_cdb2_tag", cdb2_tag, 0);
        chk("t6_pending0", 32'(pending), 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t6_leak", 32'((cdb1_tag >= 20 && cdb1_tag <= 23) ||
                               (cdb2_tag >= 20 && cdb2_tag <= 23)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
